// File: rtl/mem_stage_lsu.sv
//==============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM pipeline stage: waits for data response, aligns/extends loads,
//            handles flush with stale-response discard, forwards to ID.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_stage_lsu #(
   parameter int XLEN       = 32,
   parameter int REG_AW     = 5,
   parameter int MAX_OUTSTD = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [6+REG_AW+2*XLEN-1:0] es_to_ms_bus,
   input  logic                       ms_flush,
   input  logic                       data_sram_data_ok,
   input  logic [XLEN-1:0]            data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [1+REG_AW+2*XLEN-1:0] ms_to_ws_bus,
   output logic                       ms_fwd_valid,
   output logic [REG_AW-1:0]          ms_fwd_dest,
   output logic [XLEN-1:0]            ms_fwd_data,
   output logic                       ms_fwd_stall
);

   localparam int c_ctl_lsb = 2*XLEN + REG_AW;
   localparam int c_cnt_w   = $clog2(MAX_OUTSTD + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(MAX_OUTSTD);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_ms_valid;
   logic [c_cnt_w-1:0]   r_discard_cnt;
   logic [XLEN-1:0]      r_rdata;
   logic                 r_load_op;
   logic [1:0]           r_mem_size;
   logic                 r_load_unsigned;
   logic                 r_gr_we;
   logic [REG_AW-1:0]    r_dest;
   logic [XLEN-1:0]      r_alu_result;
   logic [XLEN-1:0]      r_pc;

   logic                 w_es_mem_req;
   logic                 w_ready_go;
   logic                 w_accept;
   logic                 w_beat_stale;
   logic [1:0]           w_off;
   logic [XLEN-1:0]      w_byte_shift;
   logic [XLEN-1:0]      w_half_shift;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [XLEN-1:0]      w_load_data;
   logic [XLEN-1:0]      w_final_result;

   assign w_es_mem_req = es_to_ms_bus[c_ctl_lsb+5];
   assign w_ready_go   = (r_state == ST_HOLD);
   assign ms_allowin   = !r_ms_valid || (w_ready_go && ws_allowin);
   assign w_accept     = es_to_ms_valid && ms_allowin;
   assign w_beat_stale = (r_discard_cnt != c_cnt_zero);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_EMPTY;
         r_ms_valid      <= 1'b0;
         r_discard_cnt   <= c_cnt_zero;
         r_rdata         <= '0;
         r_load_op       <= 1'b0;
         r_mem_size      <= 2'b00;
         r_load_unsigned <= 1'b0;
         r_gr_we         <= 1'b0;
         r_dest          <= '0;
         r_alu_result    <= '0;
         r_pc            <= '0;
      end else begin
         // A beat arriving while the counter is non-zero belongs to a killed request.
         if (data_sram_data_ok && w_beat_stale)
            r_discard_cnt <= r_discard_cnt - c_cnt_one;
         else if (ms_flush && r_state == ST_WAIT && !data_sram_data_ok &&
                  r_discard_cnt != c_cnt_max)
            r_discard_cnt <= r_discard_cnt + c_cnt_one;

         if (ms_flush) begin
            r_state    <= ST_EMPTY;
            r_ms_valid <= 1'b0;
         end else if (r_state == ST_WAIT) begin
            if (data_sram_data_ok && !w_beat_stale) begin
               r_rdata <= data_sram_rdata;
               r_state <= ST_HOLD;
            end
         end else if (w_accept) begin
            r_state         <= w_es_mem_req ? ST_WAIT : ST_HOLD;
            r_ms_valid      <= 1'b1;
            r_load_op       <= es_to_ms_bus[c_ctl_lsb+4];
            r_mem_size      <= es_to_ms_bus[c_ctl_lsb+3 -: 2];
            r_load_unsigned <= es_to_ms_bus[c_ctl_lsb+1];
            r_gr_we         <= es_to_ms_bus[c_ctl_lsb];
            r_dest          <= es_to_ms_bus[c_ctl_lsb-1 -: REG_AW];
            r_alu_result    <= es_to_ms_bus[2*XLEN-1 -: XLEN];
            r_pc            <= es_to_ms_bus[XLEN-1:0];
         end else if (r_state == ST_HOLD && ws_allowin) begin
            r_state    <= ST_EMPTY;
            r_ms_valid <= 1'b0;
         end
      end
   end

   assign w_off        = r_alu_result[1:0];
   assign w_byte_shift = r_rdata >> {w_off, 3'b000};
   assign w_half_shift = r_rdata >> {w_off[1], 4'b0000};
   assign w_byte       = w_byte_shift[7:0];
   assign w_half       = w_half_shift[15:0];

   always_comb begin
      w_load_data = r_rdata;
      case (r_mem_size)
         2'b00:   w_load_data = {{(XLEN-8){w_byte[7] && !r_load_unsigned}}, w_byte};
         2'b01:   w_load_data = {{(XLEN-16){w_half[15] && !r_load_unsigned}}, w_half};
         default: w_load_data = r_rdata;
      endcase
   end

   assign w_final_result = r_load_op ? w_load_data : r_alu_result;

   assign ms_to_ws_valid = r_ms_valid && w_ready_go;
   assign ms_to_ws_bus   = {r_gr_we, r_dest, w_final_result, r_pc};
   assign ms_fwd_valid   = r_ms_valid && r_gr_we && (r_dest != '0);
   assign ms_fwd_dest    = r_dest;
   assign ms_fwd_data    = w_final_result;
   assign ms_fwd_stall   = r_ms_valid && r_load_op && (r_state == ST_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
//==============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Directed self-checking bench for mem_stage_lsu.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_stage_lsu;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic        clk;
   logic        reset;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [74:0] es_to_ms_bus;
   logic        ms_flush;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic        ms_fwd_valid;
   logic [4:0]  ms_fwd_dest;
   logic [31:0] ms_fwd_data;
   logic        ms_fwd_stall;

   int n_tests;
   int n_fail;

   mem_stage_lsu #(.XLEN(XLEN), .REG_AW(REG_AW), .MAX_OUTSTD(2)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_flush          (ms_flush),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ms_fwd_valid      (ms_fwd_valid),
      .ms_fwd_dest       (ms_fwd_dest),
      .ms_fwd_data       (ms_fwd_data),
      .ms_fwd_stall      (ms_fwd_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [74:0] mk_bus(input logic mem_req, input logic load_op,
                                          input logic [1:0] size, input logic uns,
                                          input logic gr_we, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic [31:0] pc);
      return {mem_req, load_op, size, uns, gr_we, dest, alu, pc};
   endfunction

   function automatic logic [69:0] ws_bus(input logic gr_we, input logic [4:0] dest,
                                          input logic [31:0] res, input logic [31:0] pc);
      return {gr_we, dest, res, pc};
   endfunction

   // Single-beat memory op with data_ok in the cycle after accept.
   task automatic mem_op(input string tag, input logic [74:0] bus, input logic [31:0] rdata,
                         input logic [69:0] exp_bus);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = bus;
      tick();
      check({tag, "_wait_valid"}, 128'(ms_to_ws_valid), 128'(1'b0));
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rdata;
      tick();
      data_sram_data_ok = 1'b0;
      check({tag, "_valid"}, 128'(ms_to_ws_valid), 128'(1'b1));
      check({tag, "_bus"}, 128'(ms_to_ws_bus), 128'(exp_bus));
      tick();
      check({tag, "_drained"}, 128'(ms_to_ws_valid), 128'(1'b0));
   endtask

   initial begin
      n_tests           = 0;
      n_fail            = 0;
      reset             = 1'b1;
      ws_allowin        = 1'b1;
      es_to_ms_valid    = 1'b0;
      es_to_ms_bus      = '0;
      ms_flush          = 1'b0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = '0;
      tick();
      tick();
      check("rst_allowin", 128'(ms_allowin), 128'(1'b1));
      check("rst_valid",   128'(ms_to_ws_valid), 128'(1'b0));
      check("rst_bus",     128'(ms_to_ws_bus), 128'(0));
      check("rst_fwd",     128'({ms_fwd_valid, ms_fwd_stall, ms_fwd_dest, ms_fwd_data}), 128'(0));
      reset = 1'b0;
      tick();

      // lb at offset 3: latency check plus forwarding
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(1, 1, 2'b00, 0, 1, 5'd5, 32'h0000_1003, 32'h100);
      tick();
      check("lb_stall",   128'(ms_fwd_stall), 128'(1'b1));
      check("lb_allowin", 128'(ms_allowin), 128'(1'b0));
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h8011_2233;
      tick();
      data_sram_data_ok = 1'b0;
      check("lb_valid",    128'(ms_to_ws_valid), 128'(1'b1));
      check("lb_bus",      128'(ms_to_ws_bus), 128'(ws_bus(1, 5'd5, 32'hFFFF_FF80, 32'h100)));
      check("lb_fwd",      128'({ms_fwd_valid, ms_fwd_stall, ms_fwd_dest, ms_fwd_data}),
                           128'({1'b1, 1'b0, 5'd5, 32'hFFFF_FF80}));
      tick();
      check("lb_drained", 128'(ms_to_ws_valid), 128'(1'b0));

      mem_op("lhu", mk_bus(1, 1, 2'b01, 1, 1, 5'd6, 32'h0000_2002, 32'h104), 32'hBEEF_1234,
             ws_bus(1, 5'd6, 32'h0000_BEEF, 32'h104));
      mem_op("lh",  mk_bus(1, 1, 2'b01, 0, 1, 5'd6, 32'h0000_2002, 32'h108), 32'hBEEF_1234,
             ws_bus(1, 5'd6, 32'hFFFF_BEEF, 32'h108));
      mem_op("lbu", mk_bus(1, 1, 2'b00, 1, 1, 5'd8, 32'h0000_2001, 32'h10C), 32'h8011_A233,
             ws_bus(1, 5'd8, 32'h0000_00A2, 32'h10C));
      mem_op("sw",  mk_bus(1, 0, 2'b10, 0, 0, 5'd0, 32'h0000_3000, 32'h110), 32'h1111_1111,
             ws_bus(0, 5'd0, 32'h0000_3000, 32'h110));

      // Delayed response, WB backpressure, then back-to-back accept of an ALU op
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(1, 1, 2'b10, 0, 1, 5'd7, 32'h0000_4000, 32'h120);
      tick();
      es_to_ms_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("dly_stall",   128'(ms_fwd_stall), 128'(1'b1));
         check("dly_allowin", 128'(ms_allowin), 128'(1'b0));
         if (i < 2) tick();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hCAFE_F00D;
      ws_allowin        = 1'b0;
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         check("dly_hold_valid", 128'(ms_to_ws_valid), 128'(1'b1));
         check("dly_hold_bus",   128'(ms_to_ws_bus), 128'(ws_bus(1, 5'd7, 32'hCAFE_F00D, 32'h120)));
         check("dly_hold_allow", 128'({ms_allowin, ms_fwd_stall}), 128'(2'b00));
         if (i < 1) tick();
      end
      ws_allowin     = 1'b1;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(0, 0, 2'b10, 0, 1, 5'd9, 32'h1234_5678, 32'h124);
      #1;
      check("dly_drain_allow", 128'(ms_allowin), 128'(1'b1));
      tick();
      check("alu_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      check("alu_bus",   128'(ms_to_ws_bus), 128'(ws_bus(1, 5'd9, 32'h1234_5678, 32'h124)));

      // Flush in HOLD while EX offers a new instruction: it must be ignored
      es_to_ms_bus = mk_bus(0, 0, 2'b10, 0, 1, 5'd10, 32'h5555_0000, 32'h128);
      ms_flush     = 1'b1;
      tick();
      ms_flush       = 1'b0;
      es_to_ms_valid = 1'b0;
      check("flh_hold_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      check("flh_hold_fwd",   128'(ms_fwd_valid), 128'(1'b0));

      // Flush in WAIT: the next response beat is stale and must be dropped
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(1, 1, 2'b10, 0, 1, 5'd3, 32'h0000_5000, 32'h130);
      tick();
      es_to_ms_valid = 1'b0;
      ms_flush       = 1'b1;
      tick();
      ms_flush = 1'b0;
      check("flw_empty", 128'({ms_to_ws_valid, ms_allowin, ms_fwd_stall}), 128'(3'b010));
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(1, 1, 2'b10, 0, 1, 5'd4, 32'h0000_6000, 32'h134);
      tick();
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000_DEAD;
      tick();
      check("flw_drop_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      check("flw_drop_stall", 128'(ms_fwd_stall), 128'(1'b1));
      data_sram_rdata = 32'h0000_1234;
      tick();
      data_sram_data_ok = 1'b0;
      check("flw_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      check("flw_bus",   128'(ms_to_ws_bus), 128'(ws_bus(1, 5'd4, 32'h0000_1234, 32'h134)));
      tick();

      // Flush coincident with data_ok: no stale beat is recorded
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(1, 1, 2'b10, 0, 1, 5'd11, 32'h0000_7000, 32'h140);
      tick();
      es_to_ms_valid    = 1'b0;
      ms_flush          = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000_AAAA;
      tick();
      ms_flush          = 1'b0;
      data_sram_data_ok = 1'b0;
      check("flc_empty", 128'(ms_to_ws_valid), 128'(1'b0));
      mem_op("flc_next", mk_bus(1, 1, 2'b10, 0, 1, 5'd12, 32'h0000_7004, 32'h144), 32'h0000_5555,
             ws_bus(1, 5'd12, 32'h0000_5555, 32'h144));

      // Reset in the middle of WAIT
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(1, 1, 2'b10, 0, 1, 5'd13, 32'h0000_8000, 32'h150);
      tick();
      es_to_ms_valid = 1'b0;
      reset          = 1'b1;
      tick();
      reset = 1'b0;
      check("rstw_state", 128'({ms_to_ws_valid, ms_allowin, ms_fwd_stall, ms_fwd_valid}), 128'(4'b0100));
      mem_op("rstw_next", mk_bus(1, 1, 2'b10, 0, 1, 5'd14, 32'h0000_8004, 32'h154), 32'h0BAD_F00D,
             ws_bus(1, 5'd14, 32'h0BAD_F00D, 32'h154));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
